paddsb_seq: RTL and testbench

// - Multi-cycle lane-wise saturating adder (PADDSB) for the 16-bit ALU datapath.
// - Counterpart to the reduction unit: lanes stay separate rather than being merged into one scalar sum.
// - Each 16-bit operand is treated as NUM_LANES signed LANE_W-bit lanes.
// - One lane is processed per cycle on a single shared lane adder, trading latency for area.
// - Operands arrive and results leave over a valid/ready handshake to the execute-stage controller.

---
 rtl/paddsb_seq_pkg.sv | 13 +
 rtl/paddsb_seq_sat_add_lane.sv | 28 ++
 rtl/paddsb_seq.sv | 100 ++++++++++
 tb/tb_paddsb_seq.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/paddsb_seq_pkg.sv
// rtl/paddsb_seq_pkg.sv - shared widths and FSM encoding for the lane-wise saturating adder
package paddsb_seq_pkg;

  localparam int LANE_W_DEF    = 4;
  localparam int NUM_LANES_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/paddsb_seq_sat_add_lane.sv
// rtl/paddsb_seq_sat_add_lane.sv - combinational signed saturating adder for one lane
module sat_add_lane #(
  parameter int LANE_W = paddsb_seq_pkg::LANE_W_DEF
) (
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  output logic [LANE_W-1:0] s,
  output logic              ovfl
);

  localparam logic [LANE_W-1:0] SAT_POS = {1'b0, {(LANE_W-1){1'b1}}};
  localparam logic [LANE_W-1:0] SAT_NEG = {1'b1, {(LANE_W-1){1'b0}}};

  logic [LANE_W:0] wide;

  assign wide = {a[LANE_W-1], a} + {b[LANE_W-1], b};

  // The two top bits of the sign-extended sum disagree exactly when the result leaves lane range.
  always_comb begin
    s    = wide[LANE_W-1:0];
    ovfl = 1'b0;
    if (wide[LANE_W] != wide[LANE_W-1]) begin
      ovfl = 1'b1;
      s    = wide[LANE_W] ? SAT_NEG : SAT_POS;
    end
  end

endmodule

// File: rtl/paddsb_seq.sv
// rtl/paddsb_seq.sv - multi-cycle lane-wise saturating adder, one lane per cycle on a shared adder
module paddsb_seq
  import paddsb_seq_pkg::*;
#(
  parameter int LANE_W    = LANE_W_DEF,
  parameter int NUM_LANES = NUM_LANES_DEF,
  parameter int DATA_W    = LANE_W * NUM_LANES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    A,
  input  logic [DATA_W-1:0]    B,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    Sum,
  output logic [NUM_LANES-1:0] Ovfl_lanes,
  output logic                 Error
);

  localparam int                IDX_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_LANES - 1);

  state_t                state, state_next;
  logic [DATA_W-1:0]     a_q, b_q, sum_q;
  logic [NUM_LANES-1:0]  ovfl_q;
  logic [IDX_W-1:0]      lane_idx;
  logic [LANE_W-1:0]     lane_s;
  logic                  lane_ovfl;

  sat_add_lane #(.LANE_W(LANE_W)) u_lane (
    .a    (a_q[lane_idx*LANE_W +: LANE_W]),
    .b    (b_q[lane_idx*LANE_W +: LANE_W]),
    .s    (lane_s),
    .ovfl (lane_ovfl)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = BUSY;
      end
      BUSY: begin
        if (lane_idx == LAST_IDX) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      ovfl_q   <= '0;
      lane_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= A;
            b_q      <= B;
            sum_q    <= '0;
            ovfl_q   <= '0;
            lane_idx <= '0;
          end
        end
        BUSY: begin
          sum_q[lane_idx*LANE_W +: LANE_W] <= lane_s;
          ovfl_q[lane_idx]                 <= lane_ovfl;
          // Wraps to zero after the last lane, ready for the next operation.
          lane_idx <= (lane_idx == LAST_IDX) ? '0 : lane_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign Sum        = sum_q;
  assign Ovfl_lanes = ovfl_q;
  assign Error      = |ovfl_q;

endmodule

// File: tb/tb_paddsb_seq.sv
// tb/tb_paddsb_seq.sv - randomized and directed self-checking bench for paddsb_seq
module tb_paddsb_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] Sum;
  logic [3:0]  Ovfl_lanes;
  logic        Error;

  int checks   = 0;
  int failures = 0;

  paddsb_seq dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .A          (A),
    .B          (B),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .Sum        (Sum),
    .Ovfl_lanes (Ovfl_lanes),
    .Error      (Error)
  );

  always #5 clk = ~clk;

  function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] s, output logic [3:0] f);
    s = '0;
    f = '0;
    for (int i = 0; i < 4; i++) begin
      int x, y, t;
      x = int'(a[4*i +: 4]);
      y = int'(b[4*i +: 4]);
      if (x > 7) x -= 16;
      if (y > 7) y -= 16;
      t = x + y;
      if (t > 7) begin
        t = 7;
        f[i] = 1'b1;
      end else if (t < -8) begin
        t = -8;
        f[i] = 1'b1;
      end
      s[4*i +: 4] = 4'(t);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one operation, returns cycles from accept to out_valid and the held result, then releases it.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, output int lat,
                        output logic [15:0] s, output logic [3:0] f, output logic e);
    int w = 0;
    while (!in_ready && w < 20) begin
      step();
      w++;
    end
    A = a;
    B = b;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    s = Sum;
    f = Ovfl_lanes;
    e = Error;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || Sum !== 16'h0 || Ovfl_lanes !== 4'h0 || Error !== 1'b0) begin
      failures++;
      $display("FAIL reset: in_ready=%b out_valid=%b Sum=%h Ovfl=%b Error=%b required 1 0 0000 0000 0",
               in_ready, out_valid, Sum, Ovfl_lanes, Error);
    end
  endtask

  task automatic test_directed();
    logic [15:0] va [4] = '{16'h1234, 16'h7777, 16'h8888, 16'h7F80};
    logic [15:0] vb [4] = '{16'h1111, 16'h1111, 16'h8888, 16'h1111};
    logic [15:0] xs [4] = '{16'h2345, 16'h7777, 16'h8888, 16'h7091};
    logic [3:0]  xf [4] = '{4'b0000, 4'b1111, 4'b1111, 4'b1000};
    for (int i = 0; i < 4; i++) begin
      int lat;
      logic [15:0] s;
      logic [3:0] f;
      logic e;
      run_op(va[i], vb[i], lat, s, f, e);
      checks++;
      if (lat !== 4 || s !== xs[i] || f !== xf[i] || e !== (|xf[i])) begin
        failures++;
        $display("FAIL directed%0d: lat=%0d Sum=%h Ovfl=%b Error=%b required lat=4 Sum=%h Ovfl=%b Error=%b",
                 i, lat, s, f, e, xs[i], xf[i], |xf[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      int lat;
      logic [15:0] a, b, s, es;
      logic [3:0] f, ef;
      logic e;
      a = 16'($urandom);
      b = 16'($urandom);
      model(a, b, es, ef);
      run_op(a, b, lat, s, f, e);
      checks++;
      if (lat !== 4 || s !== es || f !== ef || e !== (|ef)) begin
        failures++;
        $display("FAIL random%0d A=%h B=%h: lat=%0d Sum=%h Ovfl=%b Error=%b required lat=4 Sum=%h Ovfl=%b Error=%b",
                 i, a, b, lat, s, f, e, es, ef, |ef);
      end
    end
  endtask

  task automatic test_backpressure();
    int w = 0;
    int lat;
    logic [15:0] s;
    logic [3:0] f;
    logic e;
    A = 16'h7F80;
    B = 16'h1111;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    while (!out_valid && w < 20) begin
      step();
      w++;
    end
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin
        A = 16'h0101;
        B = 16'h0101;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || Sum !== 16'h7091 || Ovfl_lanes !== 4'b1000 || Error !== 1'b1) begin
        failures++;
        $display("FAIL hold%0d: out_valid=%b in_ready=%b Sum=%h Ovfl=%b Error=%b required 1 0 7091 1000 1",
                 c, out_valid, in_ready, Sum, Ovfl_lanes, Error);
      end
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL release: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
    run_op(16'h2222, 16'h1111, lat, s, f, e);
    checks++;
    if (lat !== 4 || s !== 16'h3333 || f !== 4'b0000) begin
      failures++;
      $display("FAIL after_hold: lat=%0d Sum=%h Ovfl=%b required lat=4 Sum=3333 Ovfl=0000", lat, s, f);
    end
  endtask

  task automatic test_reset_mid_busy();
    int lat;
    logic [15:0] s;
    logic [3:0] f;
    logic e;
    A = 16'h7777;
    B = 16'h7777;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || Sum !== 16'h0 || Ovfl_lanes !== 4'h0 || Error !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: in_ready=%b out_valid=%b Sum=%h Ovfl=%b Error=%b required 1 0 0000 0000 0",
               in_ready, out_valid, Sum, Ovfl_lanes, Error);
    end
    run_op(16'h0001, 16'h0001, lat, s, f, e);
    checks++;
    if (lat !== 4 || s !== 16'h0002 || f !== 4'b0000 || e !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_op: lat=%0d Sum=%h Ovfl=%b Error=%b required lat=4 Sum=0002 Ovfl=0000 Error=0",
               lat, s, f, e);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
